// File: rtl/pwm_out_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_out_switch_pkg
// Brief   : Shared select codes, field geometry and defaults for the PWM switch
// Revision: 1.0 - initial release
// ============================================================================
package pwm_out_switch_pkg;

    localparam int SEL_FIELD_W       = 5;
    localparam int SEL_WORD_W        = 32;
    localparam int FIELDS_PER_WORD   = 6;
    localparam int NUM_SEL_WORDS     = 4;
    localparam int NUM_CH_DEFAULT    = 8;
    localparam int CNT_WIDTH_DEFAULT = 32;

    typedef logic [SEL_FIELD_W-1:0] sel_field_t;

    localparam sel_field_t SEL_CONST0 = 5'd16;
    localparam sel_field_t SEL_CONST1 = 5'd17;

endpackage : pwm_out_switch_pkg
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module  : pwm_channel
// Brief   : One PWM channel: free-running counter, shadow/active period+duty,
//           registered complementary A/B outputs
// Revision: 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_out_switch_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_wr,
    input  logic [CNT_WIDTH-1:0] i_period,
    input  logic [CNT_WIDTH-1:0] i_duty,
    output logic                 o_cha,
    output logic                 o_chb
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_shadow_period;
    logic [CNT_WIDTH-1:0] r_shadow_duty;
    logic [CNT_WIDTH-1:0] r_act_period;
    logic [CNT_WIDTH-1:0] r_act_duty;

    logic w_running;
    logic w_wrap;
    logic w_load;
    logic w_high;

    // Last count is period-1, so the counter never needs to hold the period itself.
    assign w_running = i_en && (r_act_period != '0);
    assign w_wrap    = w_running && (r_cnt == (r_act_period - CNT_WIDTH'(1)));
    assign w_load    = !w_running || w_wrap;
    assign w_high    = (r_cnt < r_act_duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_shadow_period <= '0;
            r_shadow_duty   <= '0;
            r_act_period    <= '0;
            r_act_duty      <= '0;
            o_cha           <= 1'b0;
            o_chb           <= 1'b0;
        end else begin
            if (i_wr) begin
                r_shadow_period <= i_period;
                r_shadow_duty   <= i_duty;
            end
            // Non-blocking read of the shadow: a write on the wrap cycle lands one period later.
            if (w_load) begin
                r_act_period <= r_shadow_period;
                r_act_duty   <= r_shadow_duty;
            end
            if (w_load) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            o_cha <= w_running && w_high;
            o_chb <= w_running && !w_high;
        end
    end

endmodule : pwm_channel
`default_nettype wire

// File: rtl/pwm_out_switch.sv
`default_nettype none
// ============================================================================
// Module  : pwm_out_switch
// Brief   : NUM_CH PWM channels routed onto OUTPUT_WIDTH pins through an
//           atomically updated 5-bit-per-pin select map
// Revision: 1.0 - initial release
// ============================================================================
module pwm_out_switch
    import pwm_out_switch_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 20,
    parameter int NUM_CH       = NUM_CH_DEFAULT,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic [NUM_CH-1:0]       En,
    input  logic                    cfg_wr,
    input  logic [2:0]              cfg_ch,
    input  logic [CNT_WIDTH-1:0]    cfg_period,
    input  logic [CNT_WIDTH-1:0]    cfg_duty,
    input  logic [SEL_WORD_W-1:0]   ChO_Sel0,
    input  logic [SEL_WORD_W-1:0]   ChO_Sel1,
    input  logic [SEL_WORD_W-1:0]   ChO_Sel2,
    input  logic [SEL_WORD_W-1:0]   ChO_Sel3,
    input  logic                    sel_update,
    output logic [OUTPUT_WIDTH-1:0] ChO,
    output logic [NUM_CH-1:0]       CHA,
    output logic [NUM_CH-1:0]       CHB
);

    localparam int c_NUM_FIELDS = NUM_SEL_WORDS * FIELDS_PER_WORD;
    localparam int c_LUT_W      = 1 << SEL_FIELD_W;

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic w_wr;
        assign w_wr = cfg_wr && (cfg_ch == 3'(gi));

        pwm_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_channel (
            .clk      (s00_axi_aclk),
            .rst_n    (s00_axi_aresetn),
            .i_en     (En[gi]),
            .i_wr     (w_wr),
            .i_period (cfg_period),
            .i_duty   (cfg_duty),
            .o_cha    (CHA[gi]),
            .o_chb    (CHB[gi])
        );
    end

    // Every 5-bit code maps to one LUT bit: channel sources, constant 1, else 0.
    logic [c_LUT_W-1:0] w_src_lut;
    always_comb begin
        w_src_lut = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_src_lut[2*i]   = CHA[i];
            w_src_lut[2*i+1] = CHB[i];
        end
        w_src_lut[SEL_CONST1] = 1'b1;
    end

    logic [NUM_SEL_WORDS*SEL_WORD_W-1:0] w_sel_words;
    logic                                w_sel_unused;
    assign w_sel_words  = {ChO_Sel3, ChO_Sel2, ChO_Sel1, ChO_Sel0};
    assign w_sel_unused = ^w_sel_words;

    logic [OUTPUT_WIDTH-1:0][SEL_FIELD_W-1:0] w_sel_field;
    logic [OUTPUT_WIDTH-1:0][SEL_FIELD_W-1:0] r_map;
    logic [OUTPUT_WIDTH-1:0]                  w_cho_next;
    logic [OUTPUT_WIDTH-1:0]                  r_cho;

    genvar gp;
    for (gp = 0; gp < OUTPUT_WIDTH; gp++) begin : g_pin
        if (gp < c_NUM_FIELDS) begin : g_field
            assign w_sel_field[gp] =
                w_sel_words[(gp / FIELDS_PER_WORD) * SEL_WORD_W
                            + (gp % FIELDS_PER_WORD) * SEL_FIELD_W +: SEL_FIELD_W];
        end else begin : g_nofield
            assign w_sel_field[gp] = SEL_CONST0;
        end
        assign w_cho_next[gp] = w_src_lut[r_map[gp]];
    end

    // The whole map is captured in one edge so pins never see a mix of old and new fields.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_map <= {OUTPUT_WIDTH{SEL_CONST0}};
            r_cho <= '0;
        end else begin
            if (sel_update) begin
                r_map <= w_sel_field;
            end
            r_cho <= w_cho_next;
        end
    end

    assign ChO = r_cho;

endmodule : pwm_out_switch
`default_nettype wire

// File: tb/tb_pwm_out_switch.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_out_switch
// Brief   : Directed vector table plus hand-written routing/reset sequences
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_out_switch;
    import pwm_out_switch_pkg::*;

    localparam int OW  = 20;
    localparam int NCH = 8;
    localparam int CW  = 32;

    logic           s00_axi_aclk    = 1'b0;
    logic           s00_axi_aresetn = 1'b0;
    logic [NCH-1:0] En              = '0;
    logic           cfg_wr          = 1'b0;
    logic [2:0]     cfg_ch          = '0;
    logic [CW-1:0]  cfg_period      = '0;
    logic [CW-1:0]  cfg_duty        = '0;
    logic [31:0]    ChO_Sel0        = '0;
    logic [31:0]    ChO_Sel1        = '0;
    logic [31:0]    ChO_Sel2        = '0;
    logic [31:0]    ChO_Sel3        = '0;
    logic           sel_update      = 1'b0;
    logic [OW-1:0]  ChO;
    logic [NCH-1:0] CHA;
    logic [NCH-1:0] CHB;

    pwm_out_switch #(
        .OUTPUT_WIDTH (OW),
        .NUM_CH       (NCH),
        .CNT_WIDTH    (CW)
    ) dut (
        .s00_axi_aclk    (s00_axi_aclk),
        .s00_axi_aresetn (s00_axi_aresetn),
        .En              (En),
        .cfg_wr          (cfg_wr),
        .cfg_ch          (cfg_ch),
        .cfg_period      (cfg_period),
        .cfg_duty        (cfg_duty),
        .ChO_Sel0        (ChO_Sel0),
        .ChO_Sel1        (ChO_Sel1),
        .ChO_Sel2        (ChO_Sel2),
        .ChO_Sel3        (ChO_Sel3),
        .sel_update      (sel_update),
        .ChO             (ChO),
        .CHA             (CHA),
        .CHB             (CHB)
    );

    always #5 s00_axi_aclk = ~s00_axi_aclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge s00_axi_aclk);
        #1;
    endtask

    function automatic logic [31:0] mk_word(input logic [4:0] f0, input logic [4:0] f1,
                                            input logic [4:0] f2, input logic [4:0] f3,
                                            input logic [4:0] f4, input logic [4:0] f5);
        return {2'b00, f5, f4, f3, f2, f1, f0};
    endfunction

    typedef struct {
        logic [7:0]  en;
        logic        wr;
        logic [2:0]  ch;
        logic [31:0] period;
        logic [31:0] duty;
        logic [7:0]  exp_cha;
        logic [7:0]  exp_chb;
    } vec_t;

    vec_t tbl[$];

    function automatic void push(input logic [7:0] en, input logic wr, input logic [2:0] ch,
                                 input logic [31:0] p, input logic [31:0] d,
                                 input logic cha0, input logic chb0);
        vec_t v;
        v.en      = en;
        v.wr      = wr;
        v.ch      = ch;
        v.period  = p;
        v.duty    = d;
        v.exp_cha = {7'b0, cha0};
        v.exp_chb = {7'b0, chb0};
        tbl.push_back(v);
    endfunction

    logic [OW-1:0] exp_cho;
    logic          prev_a;
    logic          prev_b;

    initial begin
        // Channel 0 runs 10/3; duty 7 written at cnt=4; wrap-coincident write of 2.
        push(8'd0, 1'b1, 3'd0, 32'd10, 32'd3, 1'b0, 1'b0);
        push(8'd0, 1'b0, 3'd0, 32'd0,  32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) push(8'd1, 1'b0, 3'd0, 32'd0, 32'd0, (k % 10) < 3, (k % 10) >= 3);
        for (int c = 0; c < 10; c++) push(8'd1, c == 4, 3'd0, 32'd10, 32'd7, c < 3, c >= 3);
        for (int c = 0; c < 10; c++) push(8'd1, c == 9, 3'd0, 32'd10, 32'd2, c < 7, c >= 7);
        for (int c = 0; c < 10; c++) push(8'd1, 1'b0, 3'd0, 32'd0, 32'd0, c < 7, c >= 7);
        for (int c = 0; c < 10; c++) push(8'd1, c == 5, 3'd1, 32'd4, 32'd1, c < 2, c >= 2);
        for (int c = 0; c < 10; c++) push(8'd1, 1'b0, 3'd0, 32'd0, 32'd0, c < 2, c >= 2);
        // duty 0, duty above period, period 0
        push(8'd0, 1'b1, 3'd0, 32'd10, 32'd0, 1'b0, 1'b0);
        push(8'd0, 1'b0, 3'd0, 32'd0,  32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) push(8'd1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        push(8'd0, 1'b1, 3'd0, 32'd10, 32'd12, 1'b0, 1'b0);
        push(8'd0, 1'b0, 3'd0, 32'd0,  32'd0,  1'b0, 1'b0);
        for (int k = 0; k < 12; k++) push(8'd1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        push(8'd0, 1'b1, 3'd0, 32'd0, 32'd5, 1'b0, 1'b0);
        push(8'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) push(8'd1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        tick;
        tick;
        check("reset CHA", CHA, 0);
        check("reset CHB", CHB, 0);
        check("reset ChO", ChO, 0);
        s00_axi_aresetn = 1'b1;

        foreach (tbl[i]) begin
            En         = tbl[i].en;
            cfg_wr     = tbl[i].wr;
            cfg_ch     = tbl[i].ch;
            cfg_period = tbl[i].period;
            cfg_duty   = tbl[i].duty;
            tick;
            check($sformatf("vec%0d CHA", i), CHA, tbl[i].exp_cha);
            check($sformatf("vec%0d CHB", i), CHB, tbl[i].exp_chb);
            check($sformatf("vec%0d ChO", i), ChO, 0);
        end
        cfg_wr = 1'b0;

        // Routing: pin 0 <- CHB[0], pin 19 <- constant 1, rest constant 0.
        En = '0; cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_period = 32'd10; cfg_duty = 32'd3;
        tick;
        cfg_wr = 1'b0;
        tick;
        En = 8'd1;
        ChO_Sel0 = mk_word(5'd1, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16);
        ChO_Sel1 = mk_word(5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16);
        ChO_Sel2 = mk_word(5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16);
        ChO_Sel3 = mk_word(5'd16, 5'd17, 5'd16, 5'd16, 5'd16, 5'd16);
        for (int k = 0; k < 3; k++) begin
            tick;
            check($sformatf("route pre_update%0d", k), ChO, 0);
        end
        sel_update = 1'b1;
        tick;
        sel_update = 1'b0;
        check("route update_edge", ChO, 0);
        for (int k = 0; k < 12; k++) begin
            prev_b  = CHB[0];
            tick;
            exp_cho     = '0;
            exp_cho[19] = 1'b1;
            exp_cho[0]  = prev_b;
            check($sformatf("route follow%0d", k), ChO, exp_cho);
        end

        // Atomicity: new words are ignored until sel_update, then all pins move together.
        ChO_Sel0 = mk_word(5'd0, 5'd17, 5'd16, 5'd16, 5'd16, 5'd16);
        ChO_Sel3 = mk_word(5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16);
        for (int k = 0; k < 4; k++) begin
            prev_b = CHB[0];
            tick;
            exp_cho     = '0;
            exp_cho[19] = 1'b1;
            exp_cho[0]  = prev_b;
            check($sformatf("atomic hold%0d", k), ChO, exp_cho);
        end
        sel_update = 1'b1;
        prev_b     = CHB[0];
        tick;
        sel_update  = 1'b0;
        exp_cho     = '0;
        exp_cho[19] = 1'b1;
        exp_cho[0]  = prev_b;
        check("atomic update_edge", ChO, exp_cho);
        for (int k = 0; k < 6; k++) begin
            prev_a = CHA[0];
            tick;
            exp_cho    = '0;
            exp_cho[1] = 1'b1;
            exp_cho[0] = prev_a;
            check($sformatf("atomic switched%0d", k), ChO, exp_cho);
        end

        // Reset at cnt=5 clears outputs at once; nothing restarts without new config.
        En = '0;
        tick;
        En = 8'd1;
        for (int k = 0; k < 5; k++) tick;
        #2;
        s00_axi_aresetn = 1'b0;
        #1;
        check("midreset CHA", CHA, 0);
        check("midreset CHB", CHB, 0);
        check("midreset ChO", ChO, 0);
        #3;
        s00_axi_aresetn = 1'b1;
        En = '1;
        for (int k = 0; k < 12; k++) begin
            tick;
            check($sformatf("postreset CHA%0d", k), CHA, 0);
            check($sformatf("postreset CHB%0d", k), CHB, 0);
            check($sformatf("postreset ChO%0d", k), ChO, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pwm_out_switch
`default_nettype wire
